// File: rtl/jam_cost_table_if.sv
// Cost-table port bundle: load stream, reload pulse, and the solver's lookup path.
// The checksum signal exists only when JAM_COST_CHECKSUM_EN is defined.
interface jam_cost_table_if #(
    parameter int COST_W = 7,
    parameter int IDX_W  = 3
);
    logic                  in_valid;
    logic [COST_W-1:0]     in_data;
    logic                  in_ready;
    logic                  reload;
    logic                  table_ready;
    logic [IDX_W-1:0]      W;
    logic [IDX_W-1:0]      J;
    logic [COST_W-1:0]     Cost;
`ifdef JAM_COST_CHECKSUM_EN
    logic [COST_W+2*IDX_W-1:0] checksum;
`endif

    modport master (
        output in_valid, in_data, reload, W, J,
        input  in_ready, table_ready, Cost
`ifdef JAM_COST_CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  in_valid, in_data, reload, W, J,
        output in_ready, table_ready, Cost
`ifdef JAM_COST_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/jam_cost_table.sv
// Register-based NxN cost-matrix store loaded row-major; combinational lookup once full.
// Latency: lookup 0 cycles; table serves on the cycle after the last accepted beat.
// Backpressure: in_ready=1 only while loading; optional checksum via JAM_COST_CHECKSUM_EN.
module jam_cost_table #(
    parameter int COST_W = 7,
    parameter int IDX_W  = 3
) (
    input  logic            CLK,
    input  logic            RST,
    jam_cost_table_if.slave bus
);
    localparam int PTR_W   = 2 * IDX_W;
    localparam int ENTRIES = 1 << PTR_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ENTRIES - 1);

    typedef enum logic {LOAD, SERVE} state_t;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  wptr;
    logic [COST_W-1:0] mem [ENTRIES];
    logic              in_ready, table_ready, accept, write_en;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= LOAD;
        else     state <= state_nxt;
    end

    // reload overrides a coincident beat: that beat is neither written nor counted
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        table_ready = 1'b0;
        case (state)
            LOAD:  in_ready    = 1'b1;
            SERVE: table_ready = 1'b1;
            default: ;
        endcase
        accept   = bus.in_valid && in_ready;
        write_en = accept && !bus.reload;
        if (bus.reload)
            state_nxt = LOAD;
        else if (accept && wptr == LAST_PTR)
            state_nxt = SERVE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr <= '0;
            for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
        end else if (bus.reload) begin
            wptr <= '0;
        end else if (write_en) begin
            mem[wptr] <= bus.in_data;
            wptr      <= wptr + 1'b1;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.table_ready = table_ready;
    assign bus.Cost        = table_ready ? mem[{bus.W, bus.J}] : '0;

`ifdef JAM_COST_CHECKSUM_EN
    localparam int SUM_W = COST_W + PTR_W;
    logic [SUM_W-1:0] sum;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)           sum <= '0;
        else if (bus.reload) sum <= '0;
        else if (write_en) sum <= sum + SUM_W'(bus.in_data);
    end

    assign bus.checksum = sum;
`endif
endmodule

// File: tb/tb_jam_cost_table.sv
// Directed bench for jam_cost_table; checksum checks compile in with JAM_COST_CHECKSUM_EN.
module tb_jam_cost_table;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    jam_cost_table_if #(.COST_W(7), .IDX_W(3)) bus();

    jam_cost_table #(.COST_W(7), .IDX_W(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_sum(input string tag, input int exp);
`ifdef JAM_COST_CHECKSUM_EN
        check(tag, 32'(bus.checksum), exp);
`endif
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input int d);
        bus.in_valid = 1'b1;
        bus.in_data  = 7'(d);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reload();
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
    endtask

    // mode 0: every entry == base; mode 1: base + 8w+j; mode 2: base - (8w+j)
    task automatic sweep(input string tag, input int base, input int mode);
        for (int i = 0; i < 64; i++) begin
            int exp;
            bus.W = 3'(i >> 3);
            bus.J = 3'(i);
            #1;
            exp = (mode == 0) ? base : (mode == 1) ? base + i : base - i;
            check(tag, 32'(bus.Cost), exp);
        end
    endtask

    initial begin
        int acc;
        int cyc;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.reload   = 1'b0;
        bus.W        = 3'd3;
        bus.J        = 3'd4;

        // reset values
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_table_ready", 32'(bus.table_ready), 0);
        check("rst_cost", 32'(bus.Cost), 0);
        chk_sum("rst_checksum", 0);
        #2 RST = 1'b0;
        tick();

        // load 8w+j back-to-back
        for (int i = 0; i < 63; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 7'(i);
            tick();
        end
        check("load_cost_forced0", 32'(bus.Cost), 0);
        check("tr_before_last", 32'(bus.table_ready), 0);
        check("in_ready_before_last", 32'(bus.in_ready), 1);
        beat(63);
        check("tr_after_last", 32'(bus.table_ready), 1);
        check("in_ready_after_last", 32'(bus.in_ready), 0);
        sweep("cost_ramp", 0, 1);
        chk_sum("sum_ramp", 2016);

        // reload then gapped stream of 127
        do_reload();
        check("reload_tr", 32'(bus.table_ready), 0);
        check("reload_in_ready", 32'(bus.in_ready), 1);
        check("reload_cost", 32'(bus.Cost), 0);
        chk_sum("reload_sum", 0);
        acc = 0;
        cyc = 0;
        for (int c = 0; c < 200 && !bus.table_ready; c++) begin
            bus.in_valid = (c % 2 == 0);
            bus.in_data  = 7'd127;
            if (bus.in_valid && bus.in_ready) acc++;
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("gap_accepts", acc, 64);
        check("gap_cycles", cyc, 127);
        check("gap_tr", 32'(bus.table_ready), 1);
        sweep("cost_127", 127, 0);
        chk_sum("sum_8128", 8128);

        // beats offered while serving are ignored
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 7'd5;
            #1;
            check("serve_in_ready", 32'(bus.in_ready), 0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("serve_tr_held", 32'(bus.table_ready), 1);
        sweep("serve_frozen", 127, 0);
        chk_sum("serve_sum_frozen", 8128);

        // 40 beats, then reload coincident with beat 41
        do_reload();
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 7'd9;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 7'd9;
        bus.reload   = 1'b1;
        tick();
        bus.reload   = 1'b0;
        check("coinc_tr", 32'(bus.table_ready), 0);
        chk_sum("coinc_sum_cleared", 0);
        for (int i = 0; i < 63; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 7'd1;
            tick();
        end
        check("coinc_not_done_at_63", 32'(bus.table_ready), 0);
        beat(1);
        check("coinc_done_at_64", 32'(bus.table_ready), 1);
        sweep("cost_ones", 1, 0);
        chk_sum("sum_64", 64);

        // asynchronous reset in the middle of a serving cycle
        bus.W = 3'd2;
        bus.J = 3'd5;
        #2 RST = 1'b1;
        #1;
        check("arst_serve_cost", 32'(bus.Cost), 0);
        check("arst_serve_tr", 32'(bus.table_ready), 0);
        check("arst_serve_in_ready", 32'(bus.in_ready), 1);
        tick();
        RST = 1'b0;

        // asynchronous reset during beat 30 of a load
        for (int i = 0; i < 29; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 7'd3;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 7'd3;
        #3 RST = 1'b1;
        #1;
        check("arst_load_in_ready", 32'(bus.in_ready), 1);
        check("arst_load_tr", 32'(bus.table_ready), 0);
        check("arst_load_cost", 32'(bus.Cost), 0);
        chk_sum("arst_load_sum", 0);
        bus.in_valid = 1'b0;
        tick();
        RST = 1'b0;

        // fresh load of 127 - (8w+j)
        for (int i = 0; i < 64; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 7'(127 - i);
            tick();
        end
        bus.in_valid = 1'b0;
        check("fresh_tr", 32'(bus.table_ready), 1);
        sweep("cost_desc", 127, 2);
        chk_sum("sum_6112", 6112);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete, required completion by 200000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/jam_cost_table.md
# jam_cost_table

Cost-matrix store for the job-assignment solver. It accepts an N×N cost matrix as a row-major stream over a valid/ready handshake and holds it in registers. Once loaded, it answers the solver's worker/job lookups combinationally, with zero latency. It sits directly upstream of the solver: the solver's `W`/`J` outputs drive this block's `W`/`J` inputs, and this block's `Cost` drives the solver's `Cost` input.

## Interface
- `COST_W`, default 7: width of one cost entry.
- `IDX_W`, default 3: index width; N = 2^IDX_W workers and jobs, so N² = 64 entries by default.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: upstream has a cost entry on `in_data`.
- `in_data` input COST_W: cost entry, row-major order (worker-major, then job).
- `in_ready` output 1: block accepts a beat this cycle.
- `reload` input 1: synchronous pulse that discards the table and restarts loading.
- `table_ready` output 1: all N² entries are loaded and the table is serving lookups.
- `W` input IDX_W: worker index from the solver.
- `J` input IDX_W: job index from the solver.
- `Cost` output COST_W: `mem[{W,J}]` when serving, otherwise 0.
- `checksum` output COST_W+2·IDX_W (13 bits by default): present only with `JAM_COST_CHECKSUM_EN`.

## Operation
- The block has two states:
  - LOAD: `in_ready`=1, `table_ready`=0.
  - SERVE: `in_ready`=0, `table_ready`=1.
- Reset:
  - State goes to LOAD and the 2·IDX_W-bit write counter `wptr` goes to 0.
  - All N² entries go to 0.
  - Output values: `in_ready`=1, `table_ready`=0, `Cost`=0, `checksum`=0.
- A beat is accepted when `in_valid && in_ready` on a rising edge:
  - `mem[wptr] <= in_data` and `wptr <= wptr+1`.
  - Entry `wptr` maps to worker `wptr[2·IDX_W-1:IDX_W]` and job `wptr[IDX_W-1:0]`.
- When the accepted beat has `wptr == N²-1`, the state goes to SERVE and `wptr` wraps to 0.
- SERVE:
  - `Cost = mem[{W,J}]`, purely combinational from `W`/`J`.
  - Memory is frozen, and `in_valid` is ignored.
- `reload`=1 on an edge, in either state:
  - State goes to LOAD and `wptr` goes to 0.
  - `checksum` is cleared.
  - Stale entries are kept but not served; they are overwritten by the next load.
- If `reload` and an accepted beat occur on the same edge, `reload` wins: the beat is dropped and not written.
- In LOAD, `Cost` is forced to 0 regardless of `W`/`J`.
- A partial load is not an error; the block simply waits in LOAD indefinitely.
- Asserting `RST` mid-load or mid-serve takes effect immediately (asynchronous) and produces the full reset values above.

## Timing
- The handshake is standard valid/ready, with at most one beat per cycle. `in_ready` depends only on state, never on `in_valid`.
- A full load takes N² = 64 accepting cycles minimum, back-to-back.
- If the final beat is accepted at edge k, `table_ready` is 1 and `in_ready` is 0 after edge k. The first valid lookup is in cycle k+1.
- Lookup latency is 0 cycles: `Cost` settles in the same cycle `W`/`J` change. This matches the solver sampling `Cost` at its next edge.
- If `reload` is sampled at edge r, then after edge r `table_ready`=0 and `in_ready`=1. A beat presented in cycle r+1 is entry 0.
- Gaps in `in_valid` stall `wptr` with no other effect.

## Configuration
- `JAM_COST_CHECKSUM_EN` defined:
  - Adds the `checksum` port, the unsigned sum of all accepted entries.
  - Width COST_W+2·IDX_W guarantees no overflow (max 64·127 = 8128).
  - Updated on the same edge as each accept.
  - Cleared by `RST` or `reload`; a beat dropped by a simultaneous `reload` is not added.
  - Stable and final while `table_ready`=1.
- Undefined: no `checksum` port and no adder; all other behaviour is identical.

## Test plan
- Reset, then stream entries e = (8·w + j) mod 128 back-to-back:
  - `table_ready` rises the cycle after the 64th beat.
  - Sweeping all `W`/`J` gives `Cost` = 8·W+J.
  - `checksum` = 2016.
- Stream with `in_valid` toggling every other cycle, entries all 127:
  - Load completes after 64 accepts (~128 cycles).
  - `Cost`=127 everywhere.
  - `checksum`=8128.
- In SERVE, drive `in_valid`=1 with `in_data`=5 for 10 cycles:
  - `in_ready`=0 throughout.
  - Table unchanged; `checksum` unchanged.
- Load 40 beats, then pulse `reload` on the same edge as beat 41:
  - Beat 41 is dropped, and `wptr` restarts at 0.
  - The next 64 beats of value 1 give `Cost`=1 everywhere and `checksum`=64.
- Assert `RST` asynchronously mid-cycle during beat 30:
  - Outputs immediately read `in_ready`=1, `table_ready`=0, `Cost`=0, `checksum`=0.
  - A fresh load succeeds.
- Connect to the solver with a known 8×8 matrix: the solver's MinCost/MatchCount equal the golden values for that matrix.
